// File: rtl/imem_boot_loader_if.sv
// Signal bundle between the boot loader, the UART receiver, the fetch stage and instruction memory.
// rx_valid is a one-cycle strobe with no ready: every cycle it is high delivers exactly one byte on rx_data.
interface imem_boot_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [31:0] fetch_pc;
    logic [31:0] imem_addr;
    logic        imem_we;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        load_busy;
    logic        load_done;
    logic        load_err;
    logic [15:0] words_loaded;
    logic [2:0]  dbg_state;

    modport slave (
        input  rx_valid, rx_data, fetch_pc,
        output imem_addr, imem_we, imem_wdata, cpu_rst, load_busy,
               load_done, load_err, words_loaded, dbg_state
    );

    modport master (
        output rx_valid, rx_data, fetch_pc,
        input  imem_addr, imem_we, imem_wdata, cpu_rst, load_busy,
               load_done, load_err, words_loaded, dbg_state
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Receives a framed program image over UART bytes, writes it into instruction memory
// and holds the core in reset until the whole image has landed.
module imem_boot_loader #(
    parameter int         ADDR_W      = 8,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 1_000_000,
    parameter bit         BOOT_RUN    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    imem_boot_loader_if.slave bus
);
    localparam int          TW  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

    typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_RUN} state_t;

    state_t            state;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] word_idx;
    logic [23:0]       word_buf;
    logic [TW-1:0]     tcnt;
    logic              sync_hit;
    logic              in_frame;
    logic              tmo;

    assign sync_hit = bus.rx_valid && (bus.rx_data == SYNC_BYTE);
    assign in_frame = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA);
    // A byte in the expiry cycle keeps the frame alive.
    assign tmo      = in_frame && !bus.rx_valid && (tcnt == TW'(TIMEOUT_CYC - 1));

    assign bus.imem_addr = (bus.load_busy || bus.imem_we) ? 32'({word_idx, 2'b00}) : bus.fetch_pc;
    assign bus.dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= BOOT_RUN ? S_RUN : S_IDLE;
            bus.cpu_rst      <= !BOOT_RUN;
            bus.imem_we      <= 1'b0;
            bus.imem_wdata   <= '0;
            bus.load_busy    <= 1'b0;
            bus.load_done    <= 1'b0;
            bus.load_err     <= 1'b0;
            bus.words_loaded <= '0;
            len_lo           <= '0;
            len              <= '0;
            byte_idx         <= '0;
            word_idx         <= '0;
            word_buf         <= '0;
            tcnt             <= '0;
        end else begin
            bus.imem_we   <= 1'b0;
            bus.load_done <= 1'b0;

            if (in_frame) begin
                tcnt <= bus.rx_valid ? '0 : tcnt + 1'b1;
            end

            case (state)
                S_IDLE, S_RUN: begin
                    if (sync_hit) begin
                        state            <= S_LEN_LO;
                        bus.cpu_rst      <= 1'b1;
                        bus.load_busy    <= 1'b1;
                        bus.load_err     <= 1'b0;
                        bus.words_loaded <= '0;
                        tcnt             <= '0;
                    end
                end
                S_LEN_LO: begin
                    if (bus.rx_valid) begin
                        len_lo <= bus.rx_data;
                        state  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (bus.rx_valid) begin
                        if (({bus.rx_data, len_lo} == 16'd0) || ({1'b0, bus.rx_data, len_lo} > CAP)) begin
                            bus.load_err  <= 1'b1;
                            bus.load_busy <= 1'b0;
                            state         <= S_IDLE;
                        end else begin
                            len      <= {bus.rx_data, len_lo};
                            byte_idx <= '0;
                            word_idx <= '0;
                            state    <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (bus.rx_valid) begin
                        byte_idx <= byte_idx + 1'b1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= bus.rx_data;
                            2'd1: word_buf[15:8]  <= bus.rx_data;
                            2'd2: word_buf[23:16] <= bus.rx_data;
                            default: begin
                                bus.imem_wdata <= {bus.rx_data, word_buf};
                                bus.imem_we    <= 1'b1;
                            end
                        endcase
                    end
                end
                default: state <= S_IDLE;
            endcase

            // The write cycle advances the word pointer; the last word ends the frame.
            if (bus.imem_we) begin
                word_idx         <= word_idx + 1'b1;
                bus.words_loaded <= bus.words_loaded + 16'd1;
                if ((state == S_DATA) && (16'(word_idx) == (len - 16'd1))) begin
                    state         <= S_RUN;
                    bus.cpu_rst   <= 1'b0;
                    bus.load_busy <= 1'b0;
                    bus.load_done <= 1'b1;
                end
            end

            if (tmo) begin
                bus.load_err  <= 1'b1;
                bus.load_busy <= 1'b0;
                state         <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: a byte-level frame model predicts writes and output levels
// per cycle, and a negedge process compares them against the DUT.
module tb_imem_boot_loader;
    localparam int         ADDR_W = 8;
    localparam int         TO     = 40;
    localparam logic [7:0] SYNC   = 8'hA5;
    localparam int         CAPW   = 1 << ADDR_W;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    bit          chk_en = 1'b0;
    bit          pc_rand = 1'b1;
    logic [31:0] pc_v = 32'h0;

    // scoreboard: expected writes {addr,data} with their cycle, plus level/pulse change events
    logic [63:0] exp_q[$];
    int          exp_wc_q[$];
    logic [63:0] obs_q[$];
    int          obs_cq[$];
    ev_t         ev_q[$];
    ev_t         keep_q[$];
    int          done_cnt = 0;
    logic        e_rst = 1'b1;
    logic        e_busy = 1'b0;
    logic        e_err = 1'b0;
    logic [15:0] e_wl = 16'h0;
    logic [31:0] e_laddr = 32'h0;
    logic        e_done;
    logic        e_we;
    logic [31:0] ea;
    logic [31:0] ed;

    // frame model: 0 waiting, 1 length low, 2 length high, 3 body, 4 running
    int          m_mode = 0;
    int          m_n = 0;
    int          m_widx = 0;
    int          m_last = 0;
    logic [7:0]  m_lo = 8'h0;
    logic [7:0]  m_bytes[$];
    logic [7:0]  fr[$];

    imem_boot_loader_if bus();
    imem_boot_loader_if bus2();

    imem_boot_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(SYNC), .TIMEOUT_CYC(TO), .BOOT_RUN(1'b0))
        dut (.clk(clk), .rst(rst), .bus(bus));
    imem_boot_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(SYNC), .TIMEOUT_CYC(TO), .BOOT_RUN(1'b1))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        failures++;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=0x%08h required=0x%08h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pc_rand) begin
            pc_v = $urandom & 32'hFFFF_FFFC;
            bus.fetch_pc = pc_v;
        end
    endtask

    task automatic push_ev(input int c, input int s, input logic [31:0] v);
        ev_q.push_back('{cyc: c, sig: s, val: v});
    endtask

    // byte accepted in cycle c: outputs react from c+1
    task automatic model_byte(input logic [7:0] b, input int c);
        m_last = c;
        case (m_mode)
            0, 4: begin
                if (b == SYNC) begin
                    m_mode = 1;
                    push_ev(c + 1, 0, 1);
                    push_ev(c + 1, 1, 1);
                    push_ev(c + 1, 2, 0);
                    push_ev(c + 1, 3, 0);
                end
            end
            1: begin
                m_lo = b;
                m_mode = 2;
            end
            2: begin
                m_n = int'({b, m_lo});
                if (m_n == 0 || m_n > CAPW) begin
                    push_ev(c + 1, 2, 1);
                    push_ev(c + 1, 1, 0);
                    m_mode = 0;
                end else begin
                    m_mode = 3;
                    m_widx = 0;
                    m_bytes = {};
                    push_ev(c + 1, 4, 0);
                end
            end
            default: begin
                m_bytes.push_back(b);
                if (m_bytes.size() == 4) begin
                    exp_q.push_back({32'(m_widx * 4), m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]});
                    exp_wc_q.push_back(c + 1);
                    m_widx++;
                    m_bytes = {};
                    push_ev(c + 2, 3, 32'(m_widx));
                    push_ev(c + 2, 4, 32'((m_widx % CAPW) * 4));
                    if (m_widx == m_n) begin
                        m_mode = 4;
                        push_ev(c + 2, 0, 0);
                        push_ev(c + 2, 1, 0);
                        push_ev(c + 2, 5, 1);
                    end
                end
            end
        endcase
    endtask

    // n silent cycles starting now; a frame dies TO silent cycles after its last byte
    task automatic idle(input int n);
        if (n > 0) begin
            if (m_mode >= 1 && m_mode <= 3 && (cyc + n - 1) >= m_last + TO) begin
                push_ev(m_last + TO + 1, 2, 1);
                push_ev(m_last + TO + 1, 1, 0);
                m_mode = 0;
                m_bytes = {};
            end
            repeat (n) tick();
        end
    endtask

    // driver tasks
    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data = b;
        model_byte(b, cyc);
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'($urandom);
    endtask

    task automatic send_fr(input int maxgap);
        foreach (fr[i]) begin
            send_byte(fr[i]);
            if (maxgap > 0 && i != fr.size() - 1) idle($urandom_range(0, maxgap));
        end
    endtask

    task automatic build_frame(input int n, input int nwords);
        fr = {SYNC, 8'(n), 8'(n >> 8)};
        for (int i = 0; i < nwords * 4; i++) fr.push_back(8'($urandom));
    endtask

    task automatic do_reset();
        int  r;
        ev_t tmp[$];
        r = cyc;
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        tmp = {};
        foreach (ev_q[i]) if (ev_q[i].cyc <= r) tmp.push_back(ev_q[i]);
        ev_q = tmp;
        while (exp_wc_q.size() > 0 && exp_wc_q[$] > r) begin
            void'(exp_wc_q.pop_back());
            void'(exp_q.pop_back());
        end
        push_ev(r + 1, 0, 1);
        push_ev(r + 1, 1, 0);
        push_ev(r + 1, 2, 0);
        push_ev(r + 1, 3, 0);
        push_ev(r + 1, 4, 0);
        m_mode = 0;
        m_bytes = {};
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cpu_rst"}, bus.cpu_rst, 1);
        chk({tag, "_imem_we"}, bus.imem_we, 0);
        chk({tag, "_wdata"}, bus.imem_wdata, 0);
        chk({tag, "_busy"}, bus.load_busy, 0);
        chk({tag, "_done"}, bus.load_done, 0);
        chk({tag, "_err"}, bus.load_err, 0);
        chk({tag, "_words"}, bus.words_loaded, 0);
    endtask

    // compare process
    always @(negedge clk) begin
        if (chk_en) begin
            e_done = 1'b0;
            keep_q = {};
            foreach (ev_q[i]) begin
                if (ev_q[i].cyc <= cyc) begin
                    case (ev_q[i].sig)
                        0: e_rst = ev_q[i].val[0];
                        1: e_busy = ev_q[i].val[0];
                        2: e_err = ev_q[i].val[0];
                        3: e_wl = ev_q[i].val[15:0];
                        4: e_laddr = ev_q[i].val;
                        default: if (ev_q[i].cyc == cyc) e_done = 1'b1;
                    endcase
                end else begin
                    keep_q.push_back(ev_q[i]);
                end
            end
            ev_q = keep_q;
            e_we = (exp_wc_q.size() > 0) && (exp_wc_q[0] == cyc);
            chk("cpu_rst", bus.cpu_rst, e_rst);
            chk("load_busy", bus.load_busy, e_busy);
            chk("load_err", bus.load_err, e_err);
            chk("words_loaded", bus.words_loaded, e_wl);
            chk("imem_we", bus.imem_we, e_we);
            chk("load_done", bus.load_done, e_done);
            if (e_we) begin
                {ea, ed} = exp_q.pop_front();
                void'(exp_wc_q.pop_front());
                chk("wr_addr", bus.imem_addr, ea);
                chk("wr_data", bus.imem_wdata, ed);
            end else begin
                chk("imem_addr", bus.imem_addr, e_busy ? e_laddr : pc_v);
            end
        end
        if (bus.imem_we === 1'b1) begin
            obs_q.push_back({bus.imem_addr, bus.imem_wdata});
            obs_cq.push_back(cyc);
        end
        if (bus.load_done === 1'b1) done_cnt++;
    end

    // stimulus
    initial begin
        int          nw;
        int          nd;
        int          c0;
        logic [63:0] w;
        logic [7:0]  b;

        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h0;
        bus.fetch_pc = 32'h0;
        bus2.rx_valid = 1'b0;
        bus2.rx_data = 8'h0;
        bus2.fetch_pc = 32'h0000_0100;

        do_reset();
        chk_en = 1'b1;
        chk_reset_vals("por");
        chk("boot_run_cpu_rst", bus2.cpu_rst, 0);
        chk("boot_run_addr", bus2.imem_addr, 32'h100);
        chk("boot_run_busy", bus2.load_busy, 0);
        idle(2);

        // basic load
        fr = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        nw = obs_q.size();
        nd = done_cnt;
        send_fr(0);
        idle(4);
        chk("basic_nwrites", 32'(obs_q.size() - nw), 2);
        w = obs_q[nw];
        chk("basic_w0_addr", w[63:32], 32'h0);
        chk("basic_w0_data", w[31:0], 32'h0000_0013);
        w = obs_q[nw + 1];
        chk("basic_w1_addr", w[63:32], 32'h4);
        chk("basic_w1_data", w[31:0], 32'h0010_0093);
        chk("basic_done_cnt", 32'(done_cnt - nd), 1);
        chk("basic_words", bus.words_loaded, 2);
        chk("basic_cpu_rst", bus.cpu_rst, 0);
        pc_rand = 1'b0;
        pc_v = 32'h8;
        bus.fetch_pc = 32'h8;
        #1;
        chk("basic_pc_track", bus.imem_addr, 32'h8);
        idle(2);
        pc_rand = 1'b1;

        // length errors
        nw = obs_q.size();
        fr = {8'hA5, 8'h00, 8'h00};
        send_fr(0);
        idle(3);
        chk("len0_err", bus.load_err, 1);
        chk("len0_cpu_rst", bus.cpu_rst, 1);
        chk("len0_busy", bus.load_busy, 0);
        chk("len0_nwrites", 32'(obs_q.size() - nw), 0);
        fr = {8'hA5, 8'h01, 8'h01};
        send_fr(1);
        idle(3);
        chk("len257_err", bus.load_err, 1);

        // full-capacity frame, back to back
        build_frame(CAPW, CAPW);
        send_fr(0);
        idle(4);
        chk("cap_words", bus.words_loaded, 16'(CAPW));
        chk("cap_err", bus.load_err, 0);
        chk("cap_cpu_rst", bus.cpu_rst, 0);

        // timeout with a partial second word
        nw = obs_q.size();
        build_frame(3, 0);
        for (int i = 0; i < 5; i++) fr.push_back(8'($urandom));
        send_fr(0);
        idle(TO + 5);
        chk("tmo_nwrites", 32'(obs_q.size() - nw), 1);
        chk("tmo_err", bus.load_err, 1);
        chk("tmo_cpu_rst", bus.cpu_rst, 1);
        chk("tmo_words", bus.words_loaded, 1);
        build_frame(2, 2);
        send_fr(2);
        idle(4);
        chk("after_tmo_err", bus.load_err, 0);
        chk("after_tmo_cpu_rst", bus.cpu_rst, 0);

        // reload from RUN
        nw = obs_q.size();
        nd = done_cnt;
        send_byte(8'hA5);
        chk("reload_cpu_rst", bus.cpu_rst, 1);
        fr = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_fr(0);
        idle(4);
        w = obs_q[nw];
        chk("reload_addr", w[63:32], 32'h0);
        chk("reload_data", w[31:0], 32'hDEAD_BEEF);
        chk("reload_done_cnt", 32'(done_cnt - nd), 1);
        chk("reload_run", bus.cpu_rst, 0);

        // back-to-back data bytes: writes follow the 4th and 8th data bytes
        nw = obs_q.size();
        c0 = cyc;
        build_frame(2, 2);
        send_fr(0);
        idle(4);
        chk("b2b_w0_cyc", 32'(obs_cq[nw]), 32'(c0 + 7));
        chk("b2b_w1_cyc", 32'(obs_cq[nw + 1]), 32'(c0 + 11));

        // reset mid-word, then a clean frame
        fr = {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
        send_fr(0);
        do_reset();
        chk_reset_vals("midrst");
        build_frame(3, 3);
        send_fr(1);
        idle(4);
        chk("midrst_words", bus.words_loaded, 3);
        chk("midrst_cpu_rst", bus.cpu_rst, 0);

        // random frames, length errors and line noise
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
                b = 8'($urandom);
                if (b == SYNC) b = 8'h00;
                send_byte(b);
                idle($urandom_range(0, 2));
            end
            if (k % 4 == 3) begin
                build_frame($urandom_range(CAPW + 1, 1000), 0);
            end else begin
                nd = $urandom_range(1, 8);
                build_frame(nd, nd);
            end
            send_fr(3);
            idle($urandom_range(3, 6));
        end

        // BOOT_RUN=1 instance ignores non-sync bytes
        bus2.rx_valid = 1'b1;
        bus2.rx_data = 8'h00;
        idle(1);
        bus2.rx_data = 8'hFF;
        idle(1);
        bus2.rx_valid = 1'b0;
        idle(2);
        chk("boot_run_noise_cpu_rst", bus2.cpu_rst, 0);
        chk("boot_run_noise_busy", bus2.load_busy, 0);
        chk("boot_run_noise_addr", bus2.imem_addr, 32'h100);
        chk("boot_run_noise_we", bus2.imem_we, 0);

        idle(3);
        chk("exp_q_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot and load controller for the instruction fetch datapath. It receives a program image byte-by-byte from the UART receiver and assembles little-endian 32-bit words. It writes those words into instruction memory and holds the CPU core in reset while loading. It also owns the instruction memory address port: during a load it drives the loader write address, and otherwise it passes the fetch-stage PC through. It sits between the UART RX block, the instruction memory, and the core's reset input.

## Interface
Parameters:
- ADDR_W, 8: instruction memory word-address width; capacity = 2**ADDR_W words.
- SYNC_BYTE, 8'hA5: frame start byte.
- TIMEOUT_CYC, 1_000_000: maximum idle cycles allowed between bytes inside a frame.
- BOOT_RUN, 0: state after reset. 1 = RUN (execute the existing image); 0 = IDLE (core held in reset).

Ports:
- clk  in  1  system clock; the block has one clock.
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe; rx_data holds a received byte.
- rx_data  in  8  UART received byte.
- fetch_pc  in  32  current PC from the fetch stage (byte address).
- imem_addr  out  32  instruction memory byte address (combinational mux).
- imem_we  out  1  instruction memory write enable, one-cycle pulse.
- imem_wdata  out  32  instruction memory write data.
- cpu_rst  out  1  core reset; high whenever the state is not RUN.
- load_busy  out  1  high in LEN_LO, LEN_HI and DATA.
- load_done  out  1  one-cycle pulse when a load completes.
- load_err  out  1  sticky error flag; cleared on the next accepted SYNC_BYTE.
- words_loaded  out  16  count of words written in the current or last frame.

## Operation
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, then N×4 data bytes.
  - N = {LEN_HI, LEN_LO} is the word count.
  - Each word is sent LSB first.
- States:
  - IDLE: waits for rx_data==SYNC_BYTE. On match: clear load_err and words_loaded, go to LEN_LO. Other bytes are ignored.
  - LEN_LO: latch the low byte of N, go to LEN_HI.
  - LEN_HI: latch the high byte of N.
    - If N==0 or N>2**ADDR_W: set load_err, go to IDLE.
    - Otherwise clear the byte index and word index, go to DATA.
  - DATA: shift each byte into bits [8*k+7:8*k], where k is the byte index 0..3.
    - On k==3: register the full word into imem_wdata and schedule a write.
    - When the word just scheduled is word N-1, go to RUN.
  - RUN: cpu_rst=0. If rx_valid with rx_data==SYNC_BYTE arrives, go to LEN_LO, which re-asserts cpu_rst (reload on the fly). Other bytes are ignored.
- Write: imem_we=1 for exactly one cycle, the cycle after the 4th byte is accepted.
  - Write address: imem_addr = {word_idx, 2'b00}, zero-extended to 32 bits.
  - word_idx and words_loaded increment on the same cycle as the write.
- Address mux: imem_addr = load_busy|imem_we ? loader address : fetch_pc.
- Timeout: in LEN_LO, LEN_HI or DATA, a counter increments every cycle without rx_valid and reloads to 0 on rx_valid.
  - When it reaches TIMEOUT_CYC-1: set load_err, go to IDLE.
  - Any partial word is discarded. Words already written stay written.
- Simultaneous events:
  - A byte arriving in the same cycle as a pending imem_we is accepted normally.
  - A timeout and an rx_valid in the same cycle: rx_valid wins.
- Reset: returns to IDLE, or to RUN if BOOT_RUN=1, from any state, including mid-frame.

## Timing
- Reset values:
  - cpu_rst=1 (0 if BOOT_RUN=1).
  - imem_we=0, imem_wdata=0, load_busy=0, load_done=0, load_err=0, words_loaded=0.
  - All counters 0.
- All outputs except imem_addr are registered.
- Byte-to-write latency: 4th byte accepted in cycle T → imem_we high in T+1.
- Completion: for the last word, imem_we is high in cycle T+1. In T+2 the state is RUN, cpu_rst=0 and load_done=1 (one cycle only).
- Entering LEN_LO from RUN: cpu_rst=1 in the cycle after SYNC_BYTE is accepted.
- Error: load_err rises in the cycle after the offending LEN_HI byte or the timeout expiry. It stays high until the next accepted SYNC_BYTE.
- rx_valid is sampled every cycle; no back-pressure. Back-to-back bytes on consecutive cycles are supported.

## Test plan
- Basic load: reset with BOOT_RUN=0, send A5 02 00 13 00 00 00 93 00 10 00.
  - Writes 0x00000013 @0x0 and 0x00100093 @0x4.
  - load_done pulses once, cpu_rst drops, words_loaded=2.
  - imem_addr then tracks fetch_pc=0x8.
- Length errors:
  - Send A5 00 00 → load_err=1, state IDLE, no imem_we.
  - With ADDR_W=8, send A5 01 01 (N=257) → load_err=1.
- Timeout: send A5 03 00 followed by 5 data bytes, then silence for TIMEOUT_CYC cycles.
  - Exactly 1 write occurs, load_err=1, cpu_rst stays 1.
  - A following valid frame clears load_err.
- Reload from RUN: after a completed load, send A5 01 00 EF BE AD DE.
  - cpu_rst goes high the next cycle.
  - 0xDEADBEEF is written @0x0, then RUN resumes with a load_done pulse.
- Back-to-back and reset: send 8 data bytes on consecutive cycles.
  - Writes land in the cycles after the 4th and 8th bytes.
  - Asserting rst mid-word returns to IDLE with all outputs at their reset values; the next frame loads correctly.
- BOOT_RUN=1: after reset, cpu_rst=0 and imem_addr==fetch_pc with no bytes received. Non-SYNC bytes (0x00, 0xFF) are ignored.
